// File: rtl/rotator_rr_scheduler.sv
// rotator_rr_scheduler: round-robin arbiter in front of a single shared
// 8-bit rotator. One operation is in flight at a time (IDLE -> EXEC -> RESP);
// the winner's operand is rotated and returned with its requester ID.
// Optional build macro ROT_LEFT_EN adds a per-requester rotate-left select
// (req_dir) and echoes the latched direction on res_dir.
module rotator_rr_scheduler #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ROT_LEFT_EN
  input  logic [N-1:0]     req_dir,
  output logic             res_dir,
`endif
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [8*N-1:0]   req_data,
  input  logic [3*N-1:0]   req_amt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [IDW-1:0]   res_id
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state_q;
  logic [IDW-1:0]         ptr_q;
  logic [IDW-1:0]         ptr_d;
  logic [7:0]             op_q;
  logic [2:0]             amt_q;
  logic [IDW-1:0]         id_q;
  logic                   res_valid_q;
  logic [7:0]             res_data_q;
  logic [IDW-1:0]         res_id_q;
  logic                   dir_q;
  logic                   res_dir_q;

  logic                   grant_vld;
  logic [IDW-1:0]         grant_idx;
  logic [7:0]             sel_data;
  logic [2:0]             sel_amt;
  logic                   sel_dir;
  logic [7:0]             rot_result;

  // Rotate right: the doubled word shifted right leaves the wrapped bits in the low byte.
  function automatic logic [7:0] rot_right(input logic [7:0] x, input logic [2:0] a);
    logic [15:0] t;
    t = {x, x} >> a;
    return t[7:0];
  endfunction

  // Rotate left: the doubled word shifted left leaves the wrapped bits in the high byte.
  function automatic logic [7:0] rot_left(input logic [7:0] x, input logic [2:0] a);
    logic [15:0] t;
    t = {x, x} << a;
    return t[15:8];
  endfunction

  // Round-robin search: first valid requester starting at ptr, wrapping mod N.
  always_comb begin
    logic [IDW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr_q) + k) % N);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Winner's operand, amount and direction, selected with constant slices.
  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_dir  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_amt  = req_amt[3*i +: 3];
`ifdef ROT_LEFT_EN
        sel_dir  = req_dir[i];
`endif
      end
    end
  end

  // One-hot accept, only while idle and never while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = (state_q == IDLE) && !reset && grant_vld && (grant_idx == IDW'(i));
    end
  end

  // Pointer moves to the requester after the winner, wrapping at N-1.
  always_comb begin
    ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Shared rotator on the latched operand; direction fixed right unless left is enabled.
  always_comb begin
`ifdef ROT_LEFT_EN
    rot_result = dir_q ? rot_left(op_q, amt_q) : rot_right(op_q, amt_q);
`else
    rot_result = rot_right(op_q, amt_q);
`endif
  end

  // Control FSM: grant and latch, compute, then hold the result until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      amt_q       <= '0;
      id_q        <= '0;
      dir_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_dir_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            op_q    <= sel_data;
            amt_q   <= sel_amt;
            id_q    <= grant_idx;
            dir_q   <= sel_dir;
            ptr_q   <= ptr_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= rot_result;
          res_id_q    <= id_q;
          res_dir_q   <= dir_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
`ifdef ROT_LEFT_EN
  assign res_dir   = res_dir_q;
`else
  // Direction is only observable when rotate-left is built in.
  logic unused_dir;
  assign unused_dir = res_dir_q ^ sel_dir;
`endif

endmodule

// File: doc/rotator_rr_scheduler.md
Name: rotator_rr_scheduler

Overview:
- Shares one 8-bit rotate-right datapath between N requesters using round-robin arbitration.
- Each requester presents an operand and a rotate amount on a valid/ready handshake. The block grants one requester, performs the rotation and returns the result with the winner's ID on a valid/ready result port.
- Sits between the issue logic of the multifunction shifter unit and its consumers.

Parameters:
- N, 4, number of requesters; legal values 2..8.
- IDW, 2, width of requester ID; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N  bit i high: requester i has an operation pending.
- req_ready  output  N  bit i high: requester i's operation is accepted this cycle; at most one bit high.
- req_data  input  8*N  operand for requester i in bits [8i+7:8i].
- req_amt  input  3*N  rotate amount for requester i in bits [3i+2:3i].
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  8  rotated operand.
- res_id  output  IDW  index of the requester that produced res_data.

Behaviour:
- Reset values (asynchronous, all outputs and state):
  - res_valid=0, res_data=0, res_id=0, req_ready=0.
  - rr pointer ptr=0, FSM state IDLE, internal op/amt/id registers=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping mod N.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready=0 and the FSM stays in IDLE.
  - On a grant edge: latch req_data[g], req_amt[g] and g; set ptr=(g+1) mod N; go to EXEC.
- EXEC:
  - res_data <= latched operand rotated right by latched amt (amt=0 is a pass-through; bits leaving bit 0 re-enter at bit 7).
  - res_id <= latched id; res_valid <= 1; go to RESP.
- RESP:
  - res_valid, res_data and res_id stay stable until res_ready=1.
  - On the res_valid and res_ready edge: res_valid <= 0, go to IDLE.
  - req_ready=0 for all requesters throughout RESP.
- Latency and throughput:
  - Request accepted at edge T; res_valid=1 after edge T+1.
  - With res_ready tied high, res_valid is high for exactly one cycle.
  - Peak throughput is one operation per 3 cycles.
- Requester rules:
  - A requester holds req_valid, req_data and req_amt stable until its req_ready is seen.
  - The block never grants a requester whose req_valid is low.
- Fairness:
  - With all N requesters continuously valid, grants rotate 0,1,...,N-1,0,...
  - A requester waits at most N-1 other grants.
- Wrap-around: when g=N-1, ptr returns to 0.
- res_ready high while res_valid=0 is ignored.
- Reset mid-operation: any in-flight operation is discarded, no result is emitted, and ptr returns to 0.

Optional Feature:
- Macro: ROT_LEFT_EN.
- When defined:
  - Add input req_dir (width N); bit i=1 selects rotate-left for requester i.
  - The direction is latched with the operand at grant.
  - EXEC rotates left by amt (bits leaving bit 7 re-enter at bit 0).
  - Add output res_dir (1 bit) echoing the latched direction; reset value 0.
- When undefined: neither port exists and all operations rotate right.

Test Plan:
- Reset: assert reset mid-EXEC -> immediately res_valid=0, res_data=0, req_ready=0; after release, the first grant goes to the lowest valid index.
- Single op: req 2 valid, data=8'hB4, amt=3'd3 -> req_ready[2] for one cycle; two edges later res_data=8'h96, res_id=2, res_valid=1.
- Round-robin: all 4 valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0; requester ordering never repeats early.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> outputs stable, req_ready stays 0; res_ready=1 -> next grant one cycle after return to IDLE.
- Wrap and skip: ptr=3 with only req 1 and req 3 valid -> grant 3, then 1; amt=0 with data=8'h5A -> res_data=8'h5A.
- ROT_LEFT_EN: data=8'h81, amt=1, dir=1 -> res_data=8'h03, res_dir=1; dir=0 -> res_data=8'hC0.
